// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master bus arbiter. Picks which master (M0 or M1) drives the shared
// address/data bus. M0 is the parked owner. Grants are one-hot, decode
// straight from the registered state (Moore), and change one cycle after the
// request pattern that causes the change.
//
// Build option:
//   BUS_ARB_PREEMPT_EN  defined   -> wait counter, MAX_HOLD preemption and the
//                                    preempt pulse are built.
//                       undefined -> pure owner-holds arbitration; wait_cnt
//                                    and preempt are tied to 0, MAX_HOLD is
//                                    ignored.
//
// Parameters:
//   MAX_HOLD  contended cycles a waiting master tolerates before the bus is
//             forced over to it (0 = never force). Must fit in CNT_W bits.
//   CNT_W     width of the wait counter.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   M0_req    in   master 0 requests the bus
//   M1_req    in   master 1 requests the bus
//   M0_grant  out  master 0 owns the bus
//   M1_grant  out  master 1 owns the bus
//   owner     out  current owner (0 = M0, 1 = M1); this is the FSM state
//   preempt   out  one-cycle pulse in the first cycle of a forced grant
//   wait_cnt  out  cycles the non-owner has been requesting without a grant
//
// Request/grant handshake: a master holds its req high for as long as it
// wants the bus; it owns the bus exactly in the cycles its grant is high.
// A grant is never withdrawn from an owner whose req is still high, except by
// a forced preemption (flagged by preempt). Dropping req releases the bus at
// the next edge if the other master is asking (M1 always parks back to M0).
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             M0_req,
  input  logic             M1_req,
  output logic             M0_grant,
  output logic             M1_grant,
  output logic             owner,
  output logic             preempt,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } state_t;

  state_t state;

  // Elaboration-time guard: a MAX_HOLD the counter cannot reach would make
  // preemption silently impossible.
  if (MAX_HOLD < 0 || MAX_HOLD > (2 ** CNT_W) - 1) begin : g_bad_hold
    $error("bus_arbiter: MAX_HOLD does not fit in CNT_W bits");
  end

  // The state flop itself is the grant register, so both grants and owner
  // are glitch-free flop outputs with no path from the request inputs.
  assign M0_grant = (state == GNT_M0);
  assign M1_grant = (state == GNT_M1);
  assign owner    = (state == GNT_M1);

`ifdef BUS_ARB_PREEMPT_EN

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam bit               HOLD_ON   = (MAX_HOLD != 0);

  logic             owner_req;
  logic             waiter_req;
  logic             expire;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    owner_req  = (state == GNT_M0) ? M0_req : M1_req;
    waiter_req = (state == GNT_M0) ? M1_req : M0_req;
    // Forced switch: both contend and this edge completes the MAX_HOLD-th
    // contended cycle of the waiter.
    expire     = HOLD_ON && owner_req && waiter_req && (wait_cnt == HOLD_LAST);
    // Saturating increment; only reachable past HOLD_LAST when MAX_HOLD=0.
    cnt_inc    = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= GNT_M0;
      wait_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      case (state)
        GNT_M0: begin
          if (!M0_req && M1_req) begin
            state    <= GNT_M1;
            wait_cnt <= '0;
            preempt  <= 1'b0;
          end else if (expire) begin
            state    <= GNT_M1;
            wait_cnt <= '0;
            preempt  <= 1'b1;
          end else begin
            wait_cnt <= M1_req ? cnt_inc : '0;
            preempt  <= 1'b0;
          end
        end
        GNT_M1: begin
          if (!M1_req) begin
            state    <= GNT_M0;
            wait_cnt <= '0;
            preempt  <= 1'b0;
          end else if (expire) begin
            state    <= GNT_M0;
            wait_cnt <= '0;
            preempt  <= 1'b1;
          end else begin
            wait_cnt <= M0_req ? cnt_inc : '0;
            preempt  <= 1'b0;
          end
        end
        default: begin
          state    <= GNT_M0;
          wait_cnt <= '0;
          preempt  <= 1'b0;
        end
      endcase
    end
  end

`else

  // Owner-holds only: the bus moves solely when the owner lets go.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= GNT_M0;
    end else begin
      case (state)
        GNT_M0:  if (!M0_req && M1_req) state <= GNT_M1;
        GNT_M1:  if (!M1_req)           state <= GNT_M0;
        default: state <= GNT_M0;
      endcase
    end
  end

  assign wait_cnt = '0;
  assign preempt  = 1'b0;

`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Drives two arbiters side by side: one with MAX_HOLD=4 and one with
// MAX_HOLD=0 (preemption disabled). A reference model tracks, for each
// instance, who owns the bus, how long the other master has been waiting and
// whether the last switch was forced, using plain integers. Every cycle all
// outputs of both instances are compared against that model. Directed steps
// cover the reset, handover, preemption, early-drop and mid-operation reset
// scenarios, followed by a randomized request stream with occasional resets.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int CNT_W   = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic m0_req;
  logic m1_req;

  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic             a_g0, a_g1, a_own, a_pre;
  logic [CNT_W-1:0] a_cnt;
  logic             b_g0, b_g1, b_own, b_pre;
  logic [CNT_W-1:0] b_cnt;

  bus_arbiter #(.MAX_HOLD(4), .CNT_W(CNT_W)) dut_h4 (
    .clk      (clk),
    .reset    (reset),
    .M0_req   (m0_req),
    .M1_req   (m1_req),
    .M0_grant (a_g0),
    .M1_grant (a_g1),
    .owner    (a_own),
    .preempt  (a_pre),
    .wait_cnt (a_cnt)
  );

  bus_arbiter #(.MAX_HOLD(0), .CNT_W(CNT_W)) dut_h0 (
    .clk      (clk),
    .reset    (reset),
    .M0_req   (m0_req),
    .M1_req   (m1_req),
    .M0_grant (b_g0),
    .M1_grant (b_g1),
    .owner    (b_own),
    .preempt  (b_pre),
    .wait_cnt (b_cnt)
  );

  // ---------------- reference model ----------------
  int hold_of [2] = '{4, 0};
  int m_owner [2];
  int m_wait  [2];
  int m_pre   [2];

  task automatic model_step(input int k, input bit r0, input bit r1, input bit rst);
    bit req [2];
    bit own_req, wait_req, release_bus, forced;
    if (rst) begin
      m_owner[k] = 0;
      m_wait[k]  = 0;
      m_pre[k]   = 0;
      return;
    end
    req[0]   = r0;
    req[1]   = r1;
    own_req  = req[m_owner[k]];
    wait_req = req[1 - m_owner[k]];
    // M1 hands back on dropping its request; M0 only if M1 wants the bus.
    release_bus = !own_req && (m_owner[k] == 1 || wait_req);
    forced = 1'b0;
`ifdef BUS_ARB_PREEMPT_EN
    if (!release_bus && own_req && wait_req && hold_of[k] > 0 &&
        m_wait[k] == hold_of[k] - 1)
      forced = 1'b1;
`endif
    if (release_bus || forced) begin
      m_owner[k] = 1 - m_owner[k];
      m_wait[k]  = 0;
    end else if (wait_req) begin
`ifdef BUS_ARB_PREEMPT_EN
      m_wait[k] = (m_wait[k] < CNT_SAT) ? m_wait[k] + 1 : CNT_SAT;
`else
      m_wait[k] = 0;
`endif
    end else begin
      m_wait[k] = 0;
    end
    m_pre[k] = forced ? 1 : 0;
  endtask

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_err  = 0;
  int step_n = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s step%0d: observed %0h expected %0h", tag, step_n, obs, exp_v);
    end
  endtask

  task automatic check_inst(input int k, input string nm, input logic g0, input logic g1,
                            input logic ow, input logic pr, input logic [CNT_W-1:0] cn);
    check({nm, " M0_grant"}, {7'd0, g0}, (m_owner[k] == 0) ? 8'd1 : 8'd0);
    check({nm, " M1_grant"}, {7'd0, g1}, (m_owner[k] == 1) ? 8'd1 : 8'd0);
    check({nm, " owner"},    {7'd0, ow}, 8'(m_owner[k]));
    check({nm, " preempt"},  {7'd0, pr}, 8'(m_pre[k]));
    check({nm, " wait_cnt"}, {4'd0, cn}, 8'(m_wait[k]));
    check({nm, " onehot"},   8'(g0) + 8'(g1), 8'd1);
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r0, input bit r1, input bit rst);
    m0_req = r0;
    m1_req = r1;
    reset  = rst;
    @(posedge clk);
    model_step(0, r0, r1, rst);
    model_step(1, r0, r1, rst);
    #1;
    check_inst(0, "h4", a_g0, a_g1, a_own, a_pre, a_cnt);
    check_inst(1, "h0", b_g0, b_g1, b_own, b_pre, b_cnt);
    step_n++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset  = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b1;

    // Reset held two cycles with M1 requesting: M0 stays parked.
    step(0, 1, 1);
    step(0, 1, 1);
    // Release with M0 idle: M1 granted one cycle later.
    step(0, 1, 0);
    // M1 drops: park back to M0.
    step(0, 0, 0);
    // Normal handover M0 -> M1, then M1 back.
    step(0, 1, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(0, 0, 0);

    // Sustained contention from GNT_M0: alternation every MAX_HOLD cycles on
    // the MAX_HOLD=4 instance, saturation and no preemption on MAX_HOLD=0.
    for (int i = 0; i < 20; i++) step(1, 1, 0);

    // Re-park at M0, then waiter drops early and restarts its count.
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 0);

    // Mid-operation reset: in GNT_M1 with wait_cnt at MAX_HOLD-1.
    step(0, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    step(1, 1, 1);
    step(1, 1, 0);

    // Neither requesting: both stay/park at M0.
    step(0, 0, 0);
    step(0, 0, 0);

    // Randomized request stream with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 31) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
